// File: rtl/weight_serializer.sv
// -----------------------------------------------------------------------------
// weight_serializer
//
// Accepts a block of five 40-bit weight rows (five 8-bit weights per row) in a
// single handshake. The block is then streamed out MSB-first as seven 32-bit
// words. The 200 row bits are followed by 24 zero pad bits in the last word.
// Back-to-back blocks run at one word per cycle: a new block may be accepted
// in the same cycle that the final word of the current block is taken.
//
// Only OUTPUT_WIDTH = 32 and BUFFER_WIDTH = 40 are supported, because the word
// packing slices are fixed.
//
// Parameters
//   OUTPUT_WIDTH     stream word width (32)
//   BUFFER_WIDTH     row width (40)
//   BLOCK_CNT_RESET  value BLOCK_CNT takes on reset. Leave it at 0 in normal
//                    use. Setting it to a different value lets the counter
//                    wrap be reached quickly.
//
// Ports
//   CLK                  single clock, all logic on the rising edge
//   RESET                synchronous, active-high reset
//   LOAD_VALID/READY     block handshake
//   LOAD_DATA_0..4       rows 0..4; weight 0 of each row is in bits [39:32]
//   TX_VALID/READY       output word handshake
//   TX_DATA              packed output word (0 while idle)
//   TX_LAST              high with the seventh word of a block
//   BLOCK_CNT            number of fully sent blocks, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module weight_serializer #(
  parameter int          OUTPUT_WIDTH    = 32,
  parameter int          BUFFER_WIDTH    = 40,
  parameter logic [15:0] BLOCK_CNT_RESET = 16'h0000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LOAD_VALID,
  output logic                    LOAD_READY,
  input  logic [BUFFER_WIDTH-1:0] LOAD_DATA_0,
  input  logic [BUFFER_WIDTH-1:0] LOAD_DATA_1,
  input  logic [BUFFER_WIDTH-1:0] LOAD_DATA_2,
  input  logic [BUFFER_WIDTH-1:0] LOAD_DATA_3,
  input  logic [BUFFER_WIDTH-1:0] LOAD_DATA_4,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic [OUTPUT_WIDTH-1:0] TX_DATA,
  output logic                    TX_LAST,
  output logic [15:0]             BLOCK_CNT
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_W0,
    SEND_W1,
    SEND_W2,
    SEND_W3,
    SEND_W4,
    SEND_W5,
    SEND_W6
  } state_t;

  state_t state, state_next;

  logic [BUFFER_WIDTH-1:0] row_q [5];
  logic                    load_hs;
  logic                    tx_hs;

  // LOAD_READY also opens during the last word, but only when that word is
  // being taken. This is what allows a gapless block-to-block hand-off.
  assign LOAD_READY = (state == IDLE) || ((state == SEND_W6) && TX_READY);
  assign load_hs    = LOAD_VALID && LOAD_READY;
  assign tx_hs      = TX_VALID && TX_READY;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of process order.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment up front means every path assigns
    // state_next, so no latch can be inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (load_hs) state_next = SEND_W0;
      SEND_W0: if (tx_hs)   state_next = SEND_W1;
      SEND_W1: if (tx_hs)   state_next = SEND_W2;
      SEND_W2: if (tx_hs)   state_next = SEND_W3;
      SEND_W3: if (tx_hs)   state_next = SEND_W4;
      SEND_W4: if (tx_hs)   state_next = SEND_W5;
      SEND_W5: if (tx_hs)   state_next = SEND_W6;
      SEND_W6: if (tx_hs)   state_next = load_hs ? SEND_W0 : IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: driven only from registered state and registered rows, so there
  // is no path from LOAD_DATA to TX_DATA.
  // ---------------------------------------------------------------------------
  always_comb begin
    TX_VALID = (state != IDLE);
    TX_LAST  = (state == SEND_W6);
    TX_DATA  = '0;
    unique case (state)
      SEND_W0: TX_DATA = row_q[0][39:8];
      SEND_W1: TX_DATA = {row_q[0][7:0],  row_q[1][39:16]};
      SEND_W2: TX_DATA = {row_q[1][15:0], row_q[2][39:24]};
      SEND_W3: TX_DATA = {row_q[2][23:0], row_q[3][39:32]};
      SEND_W4: TX_DATA = row_q[3][31:0];
      SEND_W5: TX_DATA = row_q[4][39:8];
      SEND_W6: TX_DATA = {row_q[4][7:0],  24'h0};
      default: TX_DATA = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row buffer: captured only on a load handshake.
  // ---------------------------------------------------------------------------
  // NOTE: the row buffer is cleared on reset so that the reset state is fully
  // defined. The buffer is only five registers, so clearing it is cheap, and
  // it keeps it out of RAM inference.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 5; i++) row_q[i] <= '0;
    end else if (load_hs) begin
      row_q[0] <= LOAD_DATA_0;
      row_q[1] <= LOAD_DATA_1;
      row_q[2] <= LOAD_DATA_2;
      row_q[3] <= LOAD_DATA_3;
      row_q[4] <= LOAD_DATA_4;
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-block counter: increments when the final word is taken, and
  // wraps naturally at 16 bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET)                          BLOCK_CNT <= BLOCK_CNT_RESET;
    else if (tx_hs && state == SEND_W6) BLOCK_CNT <= BLOCK_CNT + 16'd1;
  end

endmodule

// File: tb/tb_weight_serializer.sv
// -----------------------------------------------------------------------------
// tb_weight_serializer
//
// Self-checking bench for weight_serializer. The reference model treats a
// block as a 224-bit string: the five rows concatenated, followed by 24 zero
// bits. That string is cut into seven 32-bit words and queued, and the head of
// the queue is the word that should be on TX_DATA. A second instance with a
// preloaded block counter exercises the 0xFFFF -> 0 wrap.
// -----------------------------------------------------------------------------
module tb_weight_serializer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic [39:0] ld0, ld1, ld2, ld3, ld4;
  logic        TX_VALID;
  logic        TX_READY;
  logic [31:0] TX_DATA;
  logic        TX_LAST;
  logic [15:0] BLOCK_CNT;

  // Instance used for the counter wrap test
  logic        w_load_valid;
  logic        w_load_ready;
  logic        w_tx_valid;
  logic [31:0] w_tx_data;
  logic        w_tx_last;
  logic [15:0] w_block_cnt;

  always #5 CLK = ~CLK;

  weight_serializer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LOAD_VALID  (LOAD_VALID),
    .LOAD_READY  (LOAD_READY),
    .LOAD_DATA_0 (ld0),
    .LOAD_DATA_1 (ld1),
    .LOAD_DATA_2 (ld2),
    .LOAD_DATA_3 (ld3),
    .LOAD_DATA_4 (ld4),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .TX_DATA     (TX_DATA),
    .TX_LAST     (TX_LAST),
    .BLOCK_CNT   (BLOCK_CNT)
  );

  weight_serializer #(.BLOCK_CNT_RESET(16'hFFFE)) dut_wrap (
    .CLK         (CLK),
    .RESET       (RESET),
    .LOAD_VALID  (w_load_valid),
    .LOAD_READY  (w_load_ready),
    .LOAD_DATA_0 (ld0),
    .LOAD_DATA_1 (ld1),
    .LOAD_DATA_2 (ld2),
    .LOAD_DATA_3 (ld3),
    .LOAD_DATA_4 (ld4),
    .TX_VALID    (w_tx_valid),
    .TX_READY    (1'b1),
    .TX_DATA     (w_tx_data),
    .TX_LAST     (w_tx_last),
    .BLOCK_CNT   (w_block_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [15:0] exp_cnt = 16'h0;
  int          hs_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic [39:0] r0, r1, r2, r3, r4);
    logic [223:0] bits;
    bits = {r0, r1, r2, r3, r4, 24'h0};
    for (int k = 0; k < 7; k++) q.push_back(bits[223 - 32*k -: 32]);
  endtask

  task automatic randomize_rows();
    ld0 = {$urandom_range(255, 0), $urandom()};
    ld1 = {$urandom_range(255, 0), $urandom()};
    ld2 = {$urandom_range(255, 0), $urandom()};
    ld3 = {$urandom_range(255, 0), $urandom()};
    ld4 = {$urandom_range(255, 0), $urandom()};
  endtask

  // One clock cycle. Inputs are applied just after a falling edge, outputs are
  // compared 1 time unit later, and the model is advanced at the rising edge.
  task automatic cycle(input bit rst, input bit lv, input bit tr, input bit do_chk);
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    RESET      = rst;
    LOAD_VALID = lv;
    TX_READY   = tr;
    #1;
    e_valid = (q.size() > 0);
    e_data  = e_valid ? q[0] : 32'h0;
    e_ready = (q.size() == 0) || (q.size() == 1 && tr);
    if (do_chk) begin
      check("load_ready", {31'h0, LOAD_READY}, {31'h0, e_ready});
      check("tx_valid",   {31'h0, TX_VALID},   {31'h0, e_valid});
      check("tx_last",    {31'h0, TX_LAST},    {31'h0, (q.size() == 1)});
      check("tx_data",    TX_DATA,             e_data);
      check("block_cnt",  {16'h0, BLOCK_CNT},  {16'h0, exp_cnt});
    end
    if (TX_VALID && tr) hs_seen++;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      exp_cnt = 16'h0;
    end else begin
      if (e_valid && tr) begin
        if (q.size() == 1) exp_cnt++;
        void'(q.pop_front());
      end
      if (lv && e_ready) push_block(ld0, ld1, ld2, ld3, ld4);
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [15:0] w_exp;
    logic [39:0] b0, b1, b2, b3, b4;
    RESET        = 1'b1;
    LOAD_VALID   = 1'b0;
    TX_READY     = 1'b0;
    w_load_valid = 1'b0;
    ld0 = '0; ld1 = '0; ld2 = '0; ld3 = '0; ld4 = '0;
    @(negedge CLK);

    // Reset: the first cycle has undefined state, and the second must show
    // the reset values.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check("rst_tx_valid",   {31'h0, TX_VALID},   32'h0);
    check("rst_load_ready", {31'h0, LOAD_READY}, 32'h1);
    check("rst_block_cnt",  {16'h0, BLOCK_CNT},  32'h0);
    check("rst_tx_data",    TX_DATA,             32'h0);
    check("wrap_preload",   {16'h0, w_block_cnt}, 32'h0000FFFE);

    // Single block with known rows
    ld0 = 40'h0001020304; ld1 = 40'h1011121314; ld2 = 40'h2021222324;
    ld3 = 40'h3031323334; ld4 = 40'h4041424344;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      randomize_rows();
      cycle(0, 0, 1, 1);
    end
    cycle(0, 0, 1, 1);
    check("single_cnt", {16'h0, BLOCK_CNT}, 32'h1);
    check("single_idle_data", TX_DATA, 32'h0);

    // Backpressure: same block, with TX_READY following the 1,0,0 pattern
    ld0 = 40'h0001020304; ld1 = 40'h1011121314; ld2 = 40'h2021222324;
    ld3 = 40'h3031323334; ld4 = 40'h4041424344;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 24; i++) begin
      randomize_rows();
      cycle(0, 0, (i % 3) == 0, 1);
    end
    check("bp_cnt", {16'h0, BLOCK_CNT}, 32'h2);

    // Back-to-back blocks: B is held valid through all of A
    randomize_rows();
    cycle(0, 1, 1, 1);
    randomize_rows();
    hs_seen = 0;
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 1);
    check("b2b_words", hs_seen, 14);
    check("b2b_cnt", {16'h0, BLOCK_CNT}, 32'h4);

    // Load while busy: offer a block from W2 onwards, with the rows changing
    // until W6
    randomize_rows();
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      randomize_rows();
      cycle(0, 1, 1, 1);
    end
    b0 = 40'hA0A1A2A3A4; b1 = 40'hB0B1B2B3B4; b2 = 40'hC0C1C2C3C4;
    b3 = 40'hD0D1D2D3D4; b4 = 40'hE0E1E2E3E4;
    ld0 = b0; ld1 = b1; ld2 = b2; ld3 = b3; ld4 = b4;
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      randomize_rows();
      cycle(0, 0, 1, 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      randomize_rows();
      cycle(0, $urandom_range(1, 0) == 1, $urandom_range(3, 0) != 0, 1);
    end
    for (int i = 0; i < 30; i++) cycle(0, 0, 1, 1);

    // Mid-block reset in SEND_W3
    randomize_rows();
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
    cycle(1, 0, 1, 1);
    #1;
    check("mrst_tx_valid",   {31'h0, TX_VALID},   32'h0);
    check("mrst_load_ready", {31'h0, LOAD_READY}, 32'h1);
    check("mrst_block_cnt",  {16'h0, BLOCK_CNT},  32'h0);
    randomize_rows();
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1);
    check("mrst_fresh_cnt", {16'h0, BLOCK_CNT}, 32'h1);

    // Counter wrap on the preloaded instance (FFFE -> FFFF -> 0000 -> 0001)
    check("wrap_after_rst", {16'h0, w_block_cnt}, 32'h0000FFFE);
    w_load_valid = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      cycle(0, 0, 1, 1);
      w_exp = 16'hFFFE + 16'((k - 1) / 7);
      check("wrap_cnt", {16'h0, w_block_cnt}, {16'h0, w_exp});
    end
    check("wrap_zero_seen", {16'h0, w_block_cnt}, 32'h0001);
    w_load_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_serializer.md
WEIGHT_SERIALIZER -- requirements
Module: weight_serializer

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 32, stream word width; only 32 is supported.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 40, row width (five 8-bit weights); only 40 is supported.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port LOAD_VALID  input  1  source offers a 5-row weight block.
REQ-006 SHALL have port LOAD_READY  output  1  block accepted on the cycle LOAD_VALID & LOAD_READY.
REQ-007 SHALL have ports LOAD_DATA_0..LOAD_DATA_4  input  BUFFER_WIDTH each  rows 0..4; weight 0 of each row in bits [39:32].
REQ-008 SHALL have port TX_VALID  output  1  TX_DATA holds a valid word.
REQ-009 SHALL have port TX_READY  input  1  sink accepts the word on TX_VALID & TX_READY.
REQ-010 SHALL have port TX_DATA  output  OUTPUT_WIDTH  packed word.
REQ-011 SHALL have port TX_LAST  output  1  high with the seventh (final) word of a block.
REQ-012 SHALL have port BLOCK_CNT  output  16  count of fully sent blocks; wraps 0xFFFF->0.

Function
REQ-013 SHALL use the FSM states IDLE, SEND_W0, SEND_W1, SEND_W2, SEND_W3, SEND_W4, SEND_W5 and SEND_W6.
REQ-014 SHALL drive LOAD_READY = (state==IDLE) | (state==SEND_W6 & TX_READY).
REQ-015 SHALL, on a load handshake, register all five rows into an internal row buffer and go to SEND_W0 on the next cycle.
REQ-016 SHALL hold TX_VALID high in every SEND_Wn state and low in IDLE.
REQ-017 SHALL advance SEND_Wn to SEND_Wn+1 only on a TX handshake; without a handshake the state and TX_DATA hold.
REQ-018 SHALL, in SEND_W6 on a TX handshake, go to SEND_W0 if a load handshake occurs in the same cycle, otherwise to IDLE.
REQ-019 SHALL pack words MSB-first (r0..r4 = registered rows):
- W0 = r0[39:8]
- W1 = {r0[7:0], r1[39:16]}
- W2 = {r1[15:0], r2[39:24]}
- W3 = {r2[23:0], r3[39:32]}
- W4 = r3[31:0]
- W5 = r4[39:8]
- W6 = {r4[7:0], 24'h0}
REQ-020 SHALL drive TX_DATA and TX_LAST from registered state and registered rows only; no combinational path from LOAD_DATA to TX_DATA.
REQ-021 SHALL drive TX_LAST = (state==SEND_W6).
REQ-022 SHALL ignore LOAD_DATA changes while not in a load handshake; the row buffer changes only on a load handshake.
REQ-023 SHALL increment BLOCK_CNT by 1 on the TX handshake in SEND_W6.
REQ-024 SHALL drive TX_DATA to 0 in IDLE.
REQ-025 SHALL sustain back-to-back blocks at one word per cycle with no bubble between W6 and the next W0 when TX_READY is constantly high.

Reset
REQ-026 SHALL, while RESET is high at a clock edge, set state=IDLE, the row buffer to 0 and BLOCK_CNT=0.
REQ-027 SHALL hold outputs at their reset values TX_VALID=0, TX_LAST=0, TX_DATA=0 and LOAD_READY=1 from the cycle after RESET is sampled high.
REQ-028 SHALL, on RESET mid-block, abandon the partial block without emitting further words and leave BLOCK_CNT at 0.

Verification
REQ-029 SHALL pass the single-block test: load rows 0x0001020304, 0x1011121314, 0x2021222324, 0x3031323334, 0x4041424344 with TX_READY=1 -> 7 consecutive words 0x00010203, 0x04101112, 0x13142021, 0x22232430, 0x31323334, 0x40414243, 0x44000000; TX_LAST only on the last word; BLOCK_CNT=1.
REQ-030 SHALL pass the backpressure test: same block with TX_READY toggling 1,0,0,1,... -> identical word sequence, TX_DATA stable while TX_VALID & !TX_READY, and no word dropped or duplicated.
REQ-031 SHALL pass the back-to-back test: second block held valid during W6 with TX_READY=1 -> second block's W0 in the cycle right after W6; 14 words in 14 cycles; BLOCK_CNT=2.
REQ-032 SHALL pass the load-while-busy test: LOAD_VALID=1 during SEND_W2 -> LOAD_READY=0, the current block completes unaltered, and the new block is accepted at W6.
REQ-033 SHALL pass the mid-block reset test: RESET asserted during SEND_W3 -> the next cycle shows TX_VALID=0, LOAD_READY=1 and BLOCK_CNT=0, and a fresh block then serializes correctly.
REQ-034 SHALL pass the counter wrap test: force 65536 blocks (or preload via the test hook) -> BLOCK_CNT wraps 0xFFFF->0x0000.
